nand_pipe_checker: RTL and testbench
====================================

# nand_pipe_checker

Self-checking stimulus driver and response checker for the two-stage registered NAND pipeline (`three_flipflop`). It drives pseudo-random `a`/`b` vectors from an 8-bit LFSR into the pipeline and predicts each response. It compares the pipeline's `q_out`, fed back on `q_in`, against the prediction after the fixed pipeline latency, then reports pass/fail, an error count and the index of the first failing vector. It sits beside the pipeline in board-level self-test and bench harnesses, and shares its clock.

## Interface
- `SEED`, 8'hA5: LFSR load value on start; must be nonzero.
- `NUM_VECTORS`, 64: vectors issued per run; at least 1.
- `LATENCY`, 2: edges from a vector change on `a_out`/`b_out` until the pipeline output reflects it.
- `ERR_W`, 8: error counter width.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start_in`, input, 1: run request, sampled each edge.
- `q_in`, input, 1: pipeline output under test.
- `a_out`, output, 1: stimulus bit A, registered.
- `b_out`, output, 1: stimulus bit B, registered.
- `busy_out`, output, 1: high in RUN and DRAIN.
- `done_out`, output, 1: high in DONE.
- `pass_out`, output, 1: high in DONE when `err_count_out == 0`; low otherwise.
- `err_count_out`, output, ERR_W: mismatch count; saturates at all-ones.
- `first_fail_out`, output, VW = $clog2(NUM_VECTORS+1): index of the first mismatching vector; all-ones if none.

## Operation
- States:
  - IDLE: entered from reset.
  - RUN: `start_in` in IDLE or DONE moves to RUN.
  - DRAIN: RUN moves to DRAIN after vector NUM_VECTORS-1 is issued.
  - DONE: DRAIN moves to DONE after LATENCY+1 cycles.
- `start_in` is ignored in RUN and DRAIN.
- Start action: load LFSR with SEED, clear `err_count_out` and the vector counter, set `first_fail_out` to all-ones.
- LFSR is an 8-bit Galois right shift: `next = (lfsr >> 1) ^ (lfsr[0] ? 8'hB8 : 8'h00)`. It advances once per issued vector.
- Vector k: `a_out = lfsr[0]`, `b_out = lfsr[1]`. Expected response is `~(a & b)`.
- Outside RUN, `a_out` and `b_out` are driven 0.
- Expected bit and a valid flag enter a delay line of depth LATENCY+1. Vector k's expected bit is compared with `q_in` exactly LATENCY+1 edges after the edge that issued it.
- On a mismatch, `err_count_out` increments (saturating). If `first_fail_out` is still all-ones, the vector index is captured in it.
- In DONE, outputs hold until the next start or reset.

## Timing
- Reset (synchronous, at the edge): state IDLE; `a_out`, `b_out`, `busy_out`, `done_out`, `pass_out` = 0; `err_count_out` = 0; `first_fail_out` = all-ones; LFSR = SEED; delay line cleared.
- `start_in` high at edge S:
  - `busy_out` = 1 and vector 0 appears on `a_out`/`b_out` after S.
  - Vector k appears after edge S+k.
  - Vector k is compared at edge S+k+LATENCY+1.
- Last compare is at edge S+NUM_VECTORS+LATENCY. `done_out` = 1 and `busy_out` = 0 after edge S+NUM_VECTORS+LATENCY+1.
- Total busy cycles: NUM_VECTORS+LATENCY+1.
- Start issued from DONE: `done_out` drops at the same edge that raises `busy_out`.
- Reset during RUN or DRAIN: all in-flight compares are discarded and reset values apply at that edge. The next run reproduces the identical sequence.
- The pipeline's own `reset_n` must be deasserted before `start_in`. The checker does not drive it.

## Test plan
- Reset held 3 cycles: all outputs 0, `first_fail_out` all-ones; `start_in` held low afterwards -> still IDLE, `a_out`/`b_out` stay 0.
- Defaults with a correct pipeline model, `start_in` pulsed 1 cycle:
  - Vector 0 is a=1, b=0; vector 1 is a=0, b=1; vector 2 is a=1, b=0.
  - `done_out` rises 67 cycles after start; `pass_out` = 1, `err_count_out` = 0, `first_fail_out` = 7'h7F.
- Invert `q_in` only at vector 5's compare edge -> `err_count_out` = 1, `first_fail_out` = 5, `pass_out` = 0.
- `q_in` inverted for the entire run with NUM_VECTORS=300, ERR_W=8 -> `err_count_out` = 255 (saturated), `first_fail_out` = 0.
- Reset asserted while vector 10 is on the outputs -> IDLE and reset values at that edge. A new start reproduces vectors 0,1,2 = (1,0), (0,1), (1,0).
- `start_in` pulsed during RUN -> no effect on sequence or counts. `start_in` in DONE -> counters cleared and a fresh 67-cycle run.

Source files
------------

// File: rtl/nand_pipe_checker.sv
// Stimulus driver and response checker for a two-stage registered NAND pipeline.
// Issues LFSR vectors on a_out/b_out and scores q_in after the pipeline latency.
module nand_pipe_checker #(
  parameter logic [7:0] SEED        = 8'hA5,
  parameter int         NUM_VECTORS = 64,
  parameter int         LATENCY     = 2,
  parameter int         ERR_W       = 8,
  localparam int        VW          = $clog2(NUM_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_in,
  input  logic             q_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [ERR_W-1:0] err_count_out,
  output logic [VW-1:0]    first_fail_out
);

  localparam int             DEPTH      = LATENCY + 1;
  localparam int             DW         = $clog2(LATENCY + 2);
  localparam logic [VW-1:0]  LAST_VEC   = VW'(NUM_VECTORS - 1);
  localparam logic [DW-1:0]  LAST_DRAIN = DW'(LATENCY);
  localparam logic [7:0]     TAPS       = 8'hB8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              start_run;
  logic              issue;
  logic [7:0]        vec_src;
  logic [7:0]        lfsr;
  logic [VW-1:0]     vec_cnt;
  logic [VW-1:0]     cmp_idx;
  logic [DW-1:0]     drain_cnt;
  logic [DEPTH-1:0]  exp_dl;
  logic [DEPTH-1:0]  vld_dl;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 8'h00);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // vec_src is the vector issued at this edge: SEED on a start, else the stored LFSR.
  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    issue      = 1'b0;
    vec_src    = lfsr;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_in) begin
          state_next = S_RUN;
          start_run  = 1'b1;
          issue      = 1'b1;
          vec_src    = SEED;
        end
      end
      S_RUN: begin
        if (vec_cnt == LAST_VEC) state_next = S_DRAIN;
        else                     issue      = 1'b1;
      end
      S_DRAIN: begin
        if (drain_cnt == LAST_DRAIN) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: the delay line is a handful of flops, so it is reset like any other
  // state; a stale valid bit would otherwise score a phantom compare after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_out          <= 1'b0;
      b_out          <= 1'b0;
      lfsr           <= SEED;
      vec_cnt        <= '0;
      cmp_idx        <= '0;
      drain_cnt      <= '0;
      exp_dl         <= '0;
      vld_dl         <= '0;
      err_count_out  <= '0;
      first_fail_out <= '1;
    end else begin
      a_out <= issue & vec_src[0];
      b_out <= issue & vec_src[1];

      if (issue) lfsr <= lfsr_step(vec_src);

      if (start_run)  vec_cnt <= '0;
      else if (issue) vec_cnt <= vec_cnt + 1'b1;

      if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                  drain_cnt <= '0;

      // Stage 0 holds the vector driven this cycle; stage DEPTH-1 meets q_in.
      for (int i = DEPTH - 1; i >= 1; i--) begin
        exp_dl[i] <= exp_dl[i-1];
        vld_dl[i] <= vld_dl[i-1];
      end
      exp_dl[0] <= ~(vec_src[0] & vec_src[1]);
      vld_dl[0] <= issue;

      if (start_run) begin
        err_count_out  <= '0;
        first_fail_out <= '1;
        cmp_idx        <= '0;
      end else if (vld_dl[DEPTH-1]) begin
        cmp_idx <= cmp_idx + 1'b1;
        if (exp_dl[DEPTH-1] != q_in) begin
          if (err_count_out != '1) err_count_out <= err_count_out + 1'b1;
          if (first_fail_out == '1) first_fail_out <= cmp_idx;
        end
      end
    end
  end

  assign busy_out = (state == S_RUN) || (state == S_DRAIN);
  assign done_out = (state == S_DONE);
  assign pass_out = done_out && (err_count_out == '0);

endmodule

// File: tb/tb_nand_pipe_checker.sv
// Bench for nand_pipe_checker: two instances, each beside a behavioural NAND pipeline,
// with randomized fault injection on q_in scored against a vector-level model.
module tb_nand_pipe_checker;

  localparam logic [7:0] SEED = 8'hA5;
  localparam int N0  = 64;
  localparam int N1  = 300;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start0, start1, flip0, flip1;
  logic a0, b0, busy0, done0, pass0, q0_in;
  logic a1, b1, busy1, done1, pass1, q1_in;
  logic [7:0] err0, err1;
  logic [6:0] ff0;
  logic [8:0] ff1;

  // Correct two-stage pipelines: input register, then registered NAND.
  logic p0a, p0b, q0, p1a, p1b, q1;
  always_ff @(posedge clk) begin
    p0a <= a0;  p0b <= b0;  q0 <= ~(p0a & p0b);
    p1a <= a1;  p1b <= b1;  q1 <= ~(p1a & p1b);
  end
  assign q0_in = q0 ^ flip0;
  assign q1_in = q1 ^ flip1;

  nand_pipe_checker #(.SEED(SEED), .NUM_VECTORS(N0), .LATENCY(LAT), .ERR_W(8)) dut0 (
    .clk(clk), .reset(reset), .start_in(start0), .q_in(q0_in),
    .a_out(a0), .b_out(b0), .busy_out(busy0), .done_out(done0), .pass_out(pass0),
    .err_count_out(err0), .first_fail_out(ff0)
  );

  nand_pipe_checker #(.SEED(SEED), .NUM_VECTORS(N1), .LATENCY(LAT), .ERR_W(8)) dut1 (
    .clk(clk), .reset(reset), .start_in(start1), .q_in(q1_in),
    .a_out(a1), .b_out(b1), .busy_out(busy1), .done_out(done1), .pass_out(pass1),
    .err_count_out(err1), .first_fail_out(ff1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference vector sequence: a = lfsr[0], b = lfsr[1], LFSR stepped once per vector.
  logic [1:0] ref_vec [N0];
  bit         fl0     [N0];

  function automatic logic [7:0] galois(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic build_ref();
    logic [7:0] m = SEED;
    for (int k = 0; k < N0; k++) begin
      ref_vec[k] = {m[0], m[1]};
      m = galois(m);
    end
  endtask

  // One full run on dut0; fl0[k] inverts q_in at vector k's compare edge.
  task automatic run0(input string tag, input bit mid_start);
    int flips  = 0;
    int first  = 127;
    int done_c = -1;
    int busy_c = 0;
    int poke;
    logic [1:0] fixed [3];
    fixed[0] = 2'b10; fixed[1] = 2'b01; fixed[2] = 2'b10;
    for (int k = 0; k < N0; k++)
      if (fl0[k]) begin
        flips++;
        if (first == 127) first = k;
      end
    poke = mid_start ? int'($urandom_range(N0 + LAT - 1, 1)) : -1;

    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    check({tag, "_done_drop"}, done0, 0);
    for (int c = 0; c < N0 + LAT + 20; c++) begin
      if (done0) begin
        done_c = c;
        break;
      end
      if (busy0) busy_c++;
      if (c < N0) check($sformatf("%s_vec%0d", tag, c), {a0, b0}, ref_vec[c]);
      else        check($sformatf("%s_idle_ab%0d", tag, c), {a0, b0}, 0);
      if (c < 3)  check($sformatf("%s_fixed%0d", tag, c), {a0, b0}, fixed[c]);
      // The edge after this one compares vector c-2.
      flip0  = (c >= 2 && c - 2 < N0) ? fl0[c-2] : 1'b0;
      start0 = (c == poke);
      @(posedge clk); #1;
    end
    flip0  = 1'b0;
    start0 = 1'b0;
    check({tag, "_done_cycle"}, done_c, N0 + LAT + 1);
    check({tag, "_busy_cycles"}, busy_c, N0 + LAT + 1);
    check({tag, "_busy_low"}, busy0, 0);
    check({tag, "_err"}, err0, (flips > 255) ? 255 : flips);
    check({tag, "_first_fail"}, ff0, first);
    check({tag, "_pass"}, pass0, (flips == 0) ? 1 : 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold_done"}, done0, 1);
    check({tag, "_hold_err"}, err0, (flips > 255) ? 255 : flips);
  endtask

  initial begin
    int done_c;
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    flip0  = 1'b0;
    flip1  = 1'b0;
    build_ref();
    for (int k = 0; k < N0; k++) fl0[k] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_a", a0, 0);
    check("rst_b", b0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_err", err0, 0);
    check("rst_ff", ff0, 7'h7F);
    check("rst_ff_wide", ff1, 9'h1FF);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_ab", {a0, b0}, 0);
    check("idle_busy", busy0, 0);
    check("idle_done", done0, 0);

    run0("clean", 1'b0);

    fl0[5] = 1'b1;
    run0("v5", 1'b0);

    for (int k = 0; k < N0; k++) fl0[k] = ($urandom_range(9, 0) == 0);
    run0("rand", 1'b1);

    // Reset while vector 10 is on the outputs, with every compare failing so far.
    for (int k = 0; k < N0; k++) fl0[k] = 1'b1;
    flip0  = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_vec10", {a0, b0}, ref_vec[10]);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    flip0 = 1'b0;
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_ab", {a0, b0}, 0);
    check("mid_rst_err", err0, 0);
    check("mid_rst_ff", ff0, 7'h7F);
    check("mid_rst_done", done0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_quiet_err", err0, 0);

    for (int k = 0; k < N0; k++) fl0[k] = 1'b0;
    run0("after_rst", 1'b0);

    // Saturation on the long instance: every compare fails.
    flip1  = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    done_c = -1;
    for (int c = 0; c < N1 + 50; c++) begin
      if (done1) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    flip1 = 1'b0;
    check("sat_done_cycle", done_c, N1 + LAT + 1);
    check("sat_err", err1, 255);
    check("sat_ff", ff1, 0);
    check("sat_pass", pass1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
